// File: rtl/booth_mult_pkg.sv
// Shared constants, Booth digit encoding and carry-save helpers for the radix-4 Booth multiplier.
package booth_mult_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int NUM_PP = 8;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    typedef struct packed {
        logic [PROD_W-1:0] sum;
        logic [PROD_W-1:0] carry;
    } csa_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t d;
        case (triplet)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

    // 3:2 compressor over a full word; the carry is already weighted by 2.
    function automatic csa_t csa3(input logic [PROD_W-1:0] x,
                                  input logic [PROD_W-1:0] y,
                                  input logic [PROD_W-1:0] z);
        csa_t r;
        r.sum   = x ^ y ^ z;
        r.carry = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Selects one Booth multiple of the multiplicand (0, +-a, +-2a) at 18-bit precision.
module booth_pp_gen
    import booth_mult_pkg::*;
(
    input  logic [2:0]      triplet,
    input  logic [OP_W-1:0] a,
    output logic [OP_W+1:0] mult,
    output logic            neg
);

    booth_digit_t      digit;
    logic [OP_W+1:0]   a_ext;
    logic [OP_W+1:0]   a_dbl;

    assign digit = booth_decode(triplet);
    assign a_ext = {{2{a[OP_W-1]}}, a};
    assign a_dbl = {a[OP_W-1], a, 1'b0};

    // Negative digits output the one's complement; the +1 travels separately as neg.
    always_comb begin
        mult = '0;
        neg  = 1'b0;
        case (digit)
            POS1: mult = a_ext;
            POS2: mult = a_dbl;
            NEG1: begin
                mult = ~a_ext;
                neg  = 1'b1;
            end
            NEG2: begin
                mult = ~a_dbl;
                neg  = 1'b1;
            end
            default: mult = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_16bit_multiplier.sv
// Four-stage pipelined signed 16x16 radix-4 Booth multiplier: operand regs, partial products,
// carry-save reduction, final carry-propagate add.
module booth_radix4_16bit_multiplier
    import booth_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product
);

    logic [OP_W-1:0]   a_r;
    logic [OP_W-1:0]   b_r;
    logic [OP_W:0]     b_ext;
    logic [OP_W+1:0]   mult [NUM_PP];
    logic [NUM_PP-1:0] neg;

    logic [PROD_W-1:0] pp_next [NUM_PP];
    logic [PROD_W-1:0] corr_next;
    logic [PROD_W-1:0] pp_r [NUM_PP];
    logic [PROD_W-1:0] corr_r;

    csa_t l1a, l1b, l1c, l2a, l2b, l3, l4;
    logic [PROD_W-1:0] sum_r;
    logic [PROD_W-1:0] carry_r;

    assign b_ext = {b_r, 1'b0};

    for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
        booth_pp_gen u_pp_gen (
            .triplet (b_ext[2*i+2:2*i]),
            .a       (a_r),
            .mult    (mult[i]),
            .neg     (neg[i])
        );
    end

    // Sign-extend each multiple to the product width, weight by 4^i, and gather the
    // negate corrections into one extra operand at columns 2i.
    always_comb begin
        corr_next = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            pp_next[i]       = {{(PROD_W-OP_W-2){mult[i][OP_W+1]}}, mult[i]} << (2 * i);
            corr_next[2 * i] = neg[i];
        end
    end

    // Nine operands reduce 9 -> 6 -> 4 -> 3 -> 2.
    assign l1a = csa3(pp_r[0], pp_r[1], pp_r[2]);
    assign l1b = csa3(pp_r[3], pp_r[4], pp_r[5]);
    assign l1c = csa3(pp_r[6], pp_r[7], corr_r);
    assign l2a = csa3(l1a.sum, l1a.carry, l1b.sum);
    assign l2b = csa3(l1b.carry, l1c.sum, l1c.carry);
    assign l3  = csa3(l2a.sum, l2a.carry, l2b.sum);
    assign l4  = csa3(l3.sum, l3.carry, l2b.carry);

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            corr_r  <= '0;
            sum_r   <= '0;
            carry_r <= '0;
            product <= '0;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_r[i] <= '0;
            end
        end else begin
            a_r     <= a;
            b_r     <= b;
            corr_r  <= corr_next;
            sum_r   <= l4.sum;
            carry_r <= l4.carry;
            product <= sum_r + carry_r;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_r[i] <= pp_next[i];
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_16bit_multiplier.sv
// Scoreboard bench for the pipelined Booth multiplier: directed, held, reset and random streams.
module tb_booth_radix4_16bit_multiplier;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] product;

    logic [31:0] cur_exp;
    logic [31:0] exp_q[$];
    int          tests;
    int          fails;

    booth_radix4_16bit_multiplier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors with hand-computed products.
    localparam int N_DIR = 22;
    logic [15:0] dir_a [N_DIR] = '{
        16'sd0, 16'sd1, 16'sd1, 16'sd2, -16'sd3, -16'sd10, 16'sd123, -16'sd200,
        16'sd12345, 16'sd12345, 16'sd22624, -16'sd225, 16'sd1315, -16'sd648,
        16'h7FFF, 16'h8000, -16'sd1, 16'sd32767, 16'h8000, 16'h8000, 16'h8000, 16'sd32767
    };
    logic [15:0] dir_b [N_DIR] = '{
        16'sd0, 16'sd1, -16'sd1, 16'sd3, 16'sd7, -16'sd10, 16'sd456, 16'sd300,
        -16'sd6789, 16'sd6789, 16'sd28743, -16'sd154, -16'sd19119, 16'sd268,
        16'sd1, 16'sd1, -16'sd1, -16'sd1, -16'sd1, 16'sd2, 16'h8000, 16'sd32767
    };
    logic [31:0] dir_p [N_DIR] = '{
        32'sd0, 32'sd1, -32'sd1, 32'sd6, -32'sd21, 32'sd100, 32'sd56088, -32'sd60000,
        -32'sd83810205, 32'sd83810205, 32'sd650281632, 32'sd34650, -32'sd25141485, -32'sd173664,
        32'sd32767, 32'hFFFF_8000, 32'sd1, -32'sd32767, 32'h0000_8000, 32'hFFFF_0000,
        32'h4000_0000, 32'sd1073676289
    };

    // Sampler: the value each edge captures is due on product three edges later
    // (four counting the capture edge). A reset edge zeroes everything still in flight.
    always @(posedge clk) begin
        if (rst_n) begin
            foreach (exp_q[i]) exp_q[i] = 32'd0;
            exp_q.push_back(32'd0);
        end else begin
            exp_q.push_back(cur_exp);
        end
    end

    // Monitor: checks product once the entry due after the latest edge is in the queue.
    always @(negedge clk) begin
        logic [31:0] e;
        if (exp_q.size() >= 4) begin
            e = exp_q.pop_front();
            tests++;
            if (product !== e) begin
                fails++;
                $display("FAIL product at %0t: got %h (%0d) expected %h (%0d)",
                         $time, product, $signed(product), e, $signed(e));
            end
        end
    end

    task automatic drive(input logic r, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] e);
        rst_n   = r;
        a       = x;
        b       = y;
        cur_exp = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b1;
        a       = '0;
        b       = '0;
        cur_exp = '0;

        // Power-on reset, long enough for the first checks to see a zeroed pipeline.
        for (int i = 0; i < 6; i++) drive(1'b1, 16'd0, 16'd0, 32'd0);

        // Reset held two cycles with operands present, then released: 0 throughout, then 35.
        drive(1'b1, 16'd5, 16'd7, 32'd0);
        drive(1'b1, 16'd5, 16'd7, 32'd0);
        for (int i = 0; i < 6; i++) drive(1'b0, 16'd5, 16'd7, 32'd35);

        // Directed vectors streamed back to back, one per cycle.
        for (int i = 0; i < N_DIR; i++) drive(1'b0, dir_a[i], dir_b[i], dir_p[i]);

        // Held operands give a constant product.
        for (int i = 0; i < 6; i++) drive(1'b0, 16'h8000, 16'h8000, 32'h4000_0000);

        // Mid-stream reset flush.
        drive(1'b0, 16'sd123, 16'sd456, 32'sd56088);
        drive(1'b1, 16'sd123, 16'sd456, 32'd0);
        drive(1'b0, -16'sd3, 16'sd7, -32'sd21);
        drive(1'b0, 16'sd2, 16'sd3, 32'sd6);

        // Random signed pairs with occasional reset pulses.
        for (int i = 0; i < 10500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    drive(1'b1, 16'($urandom), 16'($urandom), 32'd0);
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive(1'b0, ra, rb, 32'($signed(ra) * $signed(rb)));
        end

        for (int i = 0; i < 6; i++) drive(1'b0, 16'd0, 16'd0, 32'd0);

        tests++;
        if (tests < 10000) begin
            fails++;
            $display("FAIL check_count: got %0d comparisons required at least 10000", tests);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
